bus_matrix_axi_slice: RTL
=========================

# bus_matrix_axi_slice

AXI4-Lite register slice inserted on each master port directly upstream of the bus matrix AXI wrapper. It registers all five channels to break the combinational paths between a master and the matrix's decoders, arbiters and muxes. Forward channels (AW, W, AR) run master → matrix, and return channels (B, R) run matrix → master. Each channel has an independent two-entry skid buffer that gives one-cycle latency at full throughput, and no payload is reordered, dropped or duplicated.

## Interface
- DATA_WIDTH, 32, data bus width; multiple of 8
- ADDR_WIDTH, 32, address width
- aclk  in  1  clock; all state updates on its rising edge
- aresetn  in  1  reset aresetn, asynchronous, active-low; clock aclk
- awaddr_i, awprot_i, awvalid_i / awready_o  in/out  ADDR_WIDTH, 3, 1 / 1  master AW channel
- wdata_i, wstrb_i, wvalid_i / wready_o  in/out  DATA_WIDTH, DATA_WIDTH/8, 1 / 1  master W channel
- bresp_o, bvalid_o / bready_i  out/in  2, 1 / 1  master B channel
- araddr_i, arprot_i, arvalid_i / arready_o  in/out  ADDR_WIDTH, 3, 1 / 1  master AR channel
- rdata_o, rresp_o, rvalid_o / rready_i  out/in  DATA_WIDTH, 2, 1 / 1  master R channel
- m_awaddr_o, m_awprot_o, m_awvalid_o / m_awready_i  out/in  as AW  matrix-side AW
- m_wdata_o, m_wstrb_o, m_wvalid_o / m_wready_i  out/in  as W  matrix-side W
- m_bresp_i, m_bvalid_i / m_bready_o  in/out  as B  matrix-side B
- m_araddr_o, m_arprot_o, m_arvalid_o / m_arready_i  out/in  as AR  matrix-side AR
- m_rdata_i, m_rresp_i, m_rvalid_i / m_rready_o  in/out  as R  matrix-side R
- idle_o  out  1  registered; 1 when all five channel buffers are empty

## Operation
- One generic buffer instance per channel, with a payload-width parameter: AW = ADDR_WIDTH+3, W = DATA_WIDTH+DATA_WIDTH/8, B = 2, AR = ADDR_WIDTH+3, R = DATA_WIDTH+2.
- Buffer state is held in main_q (drives the output) and skid_q (overflow entry), each with its own valid bit. States: EMPTY (no valid), ONE (main valid), FULL (both valid).
- Input handshake is in_valid & in_ready. Output handshake is out_valid & out_ready.
- EMPTY + input handshake → ONE, with main_q loaded.
- ONE:
  - Input and output handshakes in the same cycle → ONE, main_q reloaded.
  - Input handshake only → FULL, skid_q loaded.
  - Output handshake only → EMPTY.
- FULL:
  - Output handshake → ONE, main_q ← skid_q.
  - Input handshake cannot occur because in_ready = 0.
- in_ready is a registered value equal to !skid_valid. out_valid is main_valid. Neither has a combinational path from input to output.
- Payload on the output holds stable while out_valid & !out_ready, as AXI requires.
- Channels are fully independent. W may be accepted before, with, or after its AW. No cross-channel ordering is imposed.
- idle_o = !(any main_valid or skid_valid), registered.

## Timing
- Reset (asynchronous assertion): all valid outputs are 0, all ready outputs are 0, all payload outputs are 0, idle_o = 1, and every buffer is EMPTY.
- Ready outputs go to 1 on the first aclk edge after aresetn deasserts.
- Latency: a handshake at the input on edge N presents out_valid after edge N, i.e. one cycle.
- Throughput: one beat per cycle per channel while the downstream ready is high.
- Downstream stall: the buffer accepts exactly one extra beat, then deasserts in_ready on the following cycle.
- Backpressure release: a downstream ready rising while FULL drains skid to main in one cycle. in_ready returns to 1 the cycle after.
- Reset asserted mid-transfer: all buffered beats are discarded with no output handshake. Masters and slaves must be reset together.

## Configuration
- BUS_MATRIX_AXI_SLICE_SKID_EN defined: two-entry skid behaviour as specified above, full throughput.
- Undefined: skid_q is removed and each channel becomes a single register with in_ready = !main_valid.
  - Latency stays at 1 cycle.
  - Maximum throughput drops to one beat per 2 cycles.
  - idle_o semantics are unchanged.

## Test plan
- Reset, then hold awvalid_i = 1 with awaddr_i = 0x1000_0004, m_awready_i = 1 → m_awvalid_o rises 1 cycle later with 0x1000_0004; awready_o is 0 during reset and 1 from the first edge after.
- Stream 8 W beats (0x0…0x7) with m_wready_i = 1 → 8 beats out in order on consecutive cycles (skid build), or on alternate cycles (no skid).
- m_rready_o path: send R 0xDEAD_BEEF, RRESP=2 with rready_i = 0 for 5 cycles → rvalid_o held and rdata_o stable; m_rready_o drops after the second beat is buffered; no beat is lost once rready_i = 1.
- Simultaneous AW and W beats with m_awready_i = 0, m_wready_i = 1 → W passes in 1 cycle while AW waits, with payload stable.
- Assert aresetn = 0 while the B buffer is FULL → bvalid_o = 0 immediately and idle_o = 1; no stale BRESP appears after release.
- Random valid/ready toggling on all channels for 10k cycles → scoreboard shows in-order, lossless, duplicate-free transfer, and no valid drops without a handshake.

Source files
------------

// File: rtl/bus_matrix_axi_slice.sv
// bus_matrix_axi_slice
//   AXI4-Lite register slice placed on a master port in front of the bus
//   matrix wrapper. Every channel (AW, W, B, AR, R) passes through its own
//   buffer, so there is no combinational path from either side to the other.
//   Each buffer has one-cycle latency and never reorders, drops or duplicates
//   beats.
//
//   Configuration macro: BUS_MATRIX_AXI_SLICE_SKID_EN
//     defined   : two-entry skid buffers, one beat per cycle per channel.
//     undefined : single-register buffers, ready = !main_valid, so the peak
//                 rate is one beat every two cycles.
//
//   Ports
//     aclk, aresetn          clock, asynchronous active-low reset
//     aw*/w*/ar*  _i / *ready_o      master-side forward channels (inputs)
//     b*/r*       _o / *ready_i      master-side return channels (outputs)
//     m_aw*/m_w*/m_ar* _o / _i       matrix-side forward channels
//     m_b*/m_r*  _i / m_*ready_o     matrix-side return channels
//     idle_o                 registered; 1 when every channel buffer is empty

// Generic one-channel buffer. main_q always drives the output; skid_q holds
// the beat accepted during the cycle in which the consumer stalled.
module bus_matrix_axi_slice_buf #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             empty_next
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_next;
  logic [WIDTH-1:0] main_q;
  logic             in_ready_q;
  logic             in_hs, out_hs;
  logic             load_main;
`ifdef BUS_MATRIX_AXI_SLICE_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic             load_skid;
  logic             skid_to_main;
`endif

  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_next   = state_q;
    load_main    = 1'b0;
`ifdef BUS_MATRIX_AXI_SLICE_SKID_EN
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (in_hs) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
`ifdef BUS_MATRIX_AXI_SLICE_SKID_EN
        if (in_hs && out_hs) begin
          load_main = 1'b1;
        end else if (in_hs) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (out_hs) begin
          state_next = EMPTY;
        end
`else
        // in_ready is low whenever main is valid, so only a drain can happen.
        if (out_hs) begin
          state_next = EMPTY;
        end
`endif
      end
`ifdef BUS_MATRIX_AXI_SLICE_SKID_EN
      FULL: begin
        // in_ready is low here, so no input handshake to consider.
        if (out_hs) begin
          state_next   = ONE;
          skid_to_main = 1'b1;
        end
      end
`endif
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
    end else begin
      state_q <= state_next;
`ifdef BUS_MATRIX_AXI_SLICE_SKID_EN
      in_ready_q <= (state_next != FULL);
      if (load_main) begin
        main_q <= in_data;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
`else
      in_ready_q <= (state_next == EMPTY);
      if (load_main) begin
        main_q <= in_data;
      end
`endif
    end
  end

`ifdef BUS_MATRIX_AXI_SLICE_SKID_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_q;
  assign empty_next = (state_next == EMPTY);
endmodule

module bus_matrix_axi_slice #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [2:0]              awprot_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [2:0]              arprot_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic [2:0]              m_awprot_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  input  logic [1:0]              m_bresp_i,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o,
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic [2:0]              m_arprot_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]              m_rresp_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  output logic                    idle_o
);
  localparam int AW_W = ADDR_WIDTH + 3;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8;
  localparam int B_W  = 2;
  localparam int AR_W = ADDR_WIDTH + 3;
  localparam int R_W  = DATA_WIDTH + 2;

  logic [4:0] empty_next;
  logic       idle_q;

  bus_matrix_axi_slice_buf #(.WIDTH(AW_W)) u_aw (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({awprot_i, awaddr_i}), .in_valid(awvalid_i), .in_ready(awready_o),
    .out_data({m_awprot_o, m_awaddr_o}), .out_valid(m_awvalid_o), .out_ready(m_awready_i),
    .empty_next(empty_next[0])
  );

  bus_matrix_axi_slice_buf #(.WIDTH(W_W)) u_w (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({wstrb_i, wdata_i}), .in_valid(wvalid_i), .in_ready(wready_o),
    .out_data({m_wstrb_o, m_wdata_o}), .out_valid(m_wvalid_o), .out_ready(m_wready_i),
    .empty_next(empty_next[1])
  );

  bus_matrix_axi_slice_buf #(.WIDTH(B_W)) u_b (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(m_bresp_i), .in_valid(m_bvalid_i), .in_ready(m_bready_o),
    .out_data(bresp_o), .out_valid(bvalid_o), .out_ready(bready_i),
    .empty_next(empty_next[2])
  );

  bus_matrix_axi_slice_buf #(.WIDTH(AR_W)) u_ar (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({arprot_i, araddr_i}), .in_valid(arvalid_i), .in_ready(arready_o),
    .out_data({m_arprot_o, m_araddr_o}), .out_valid(m_arvalid_o), .out_ready(m_arready_i),
    .empty_next(empty_next[3])
  );

  bus_matrix_axi_slice_buf #(.WIDTH(R_W)) u_r (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({m_rresp_i, m_rdata_i}), .in_valid(m_rvalid_i), .in_ready(m_rready_o),
    .out_data({rresp_o, rdata_o}), .out_valid(rvalid_o), .out_ready(rready_i),
    .empty_next(empty_next[4])
  );

  // Registering the next-state emptiness keeps idle_o aligned with the
  // buffer contents visible on the outputs in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idle_q <= 1'b1;
    end else begin
      idle_q <= &empty_next;
    end
  end

  assign idle_o = idle_q;
endmodule
